// File: rtl/pe_relu_unit.sv
// ---------------------------------------------------------------------------
// pe_relu_unit
//
// Rectified-linear activation stage for the PE datapath. A signed W-bit
// accumulator result is clamped to zero when negative and passed unchanged
// otherwise. Two views of the result are provided:
//   * dout      - combinational, zero latency, for direct chaining
//   * dout_q    - registered, one cycle latency, qualified by out_valid
//
// Optional feature (macro PE_RELU_CLIP_CNT_EN):
//   Adds a saturating counter of clipped (negative) valid samples, with a
//   synchronous clear. When the macro is undefined the clr_cnt/clip_cnt
//   ports and the counter logic are absent; all other behaviour is the same.
//
// Parameters:
//   W      - data width, two's-complement signed (default 24)
//   CNT_W  - clip counter width (default 16)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   din       in   W   activation input (signed)
//   in_valid  in   1   din valid this cycle (registered path and counter)
//   dout      out  W   relu(din), combinational, unaffected by reset
//   dout_q    out  W   registered relu result, held while in_valid=0
//   out_valid out  1   dout_q holds a result captured on the previous edge
//   clr_cnt   in   1   synchronous clear of clip_cnt (macro only)
//   clip_cnt  out  CNT_W count of clipped samples, saturating (macro only)
// ---------------------------------------------------------------------------
module pe_relu_unit #(
    parameter int W     = 24,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [W-1:0] din,
    input  logic                in_valid,
    output logic signed [W-1:0] dout,
    output logic signed [W-1:0] dout_q,
    output logic                out_valid
`ifdef PE_RELU_CLIP_CNT_EN
    ,
    input  logic                clr_cnt,
    output logic [CNT_W-1:0]    clip_cnt
`endif
);

    // Elaboration-time sanity checks on the configuration.
    if (W < 2) begin : g_bad_w
        $error("pe_relu_unit: W must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pe_relu_unit: CNT_W must be at least 1");
    end

    // -----------------------------------------------------------------------
    // Combinational ReLU. The sign bit alone decides: the most-negative value
    // has its sign bit set and therefore maps to zero like any other negative.
    // -----------------------------------------------------------------------
    logic              w_neg;
    logic signed [W-1:0] w_relu;

    assign w_neg  = din[W-1];
    assign w_relu = w_neg ? '0 : din;
    assign dout   = w_relu;

    // -----------------------------------------------------------------------
    // Registered path. out_valid simply follows in_valid by one cycle; the
    // data register only loads on valid samples so it holds the last result.
    // -----------------------------------------------------------------------
    logic signed [W-1:0] r_dout_q;
    logic                r_out_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_dout_q    <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_dout_q <= w_relu;
            end
        end
    end

    assign dout_q    = r_dout_q;
    assign out_valid = r_out_valid;

`ifdef PE_RELU_CLIP_CNT_EN
    // -----------------------------------------------------------------------
    // Clip counter. Clear wins over a simultaneous increment; once at the
    // all-ones value the counter sticks there until cleared.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] r_clip_cnt;
    logic             w_cnt_inc;
    logic             w_cnt_sat;

    assign w_cnt_inc = in_valid & w_neg;
    assign w_cnt_sat = &r_clip_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clip_cnt <= '0;
        end else if (clr_cnt) begin
            r_clip_cnt <= '0;
        end else if (w_cnt_inc && !w_cnt_sat) begin
            r_clip_cnt <= r_clip_cnt + 1'b1;
        end
    end

    assign clip_cnt = r_clip_cnt;
`endif

endmodule

// File: tb/tb_pe_relu_unit.sv
// ---------------------------------------------------------------------------
// tb_pe_relu_unit
//
// Self-checking bench for pe_relu_unit with W=24, CNT_W=2. Combinational
// vectors come from a table; the registered path, asynchronous reset and
// (when PE_RELU_CLIP_CNT_EN is defined) the clip counter are exercised with
// short hand-written sequences. Inputs change 1 ns after a rising edge and
// outputs are sampled there too, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_pe_relu_unit;

    localparam int W     = 24;
    localparam int CNT_W = 2;

    logic                clk;
    logic                clk_run;
    logic                rst_n;
    logic signed [W-1:0] din;
    logic                in_valid;
    logic signed [W-1:0] dout;
    logic signed [W-1:0] dout_q;
    logic                out_valid;
`ifdef PE_RELU_CLIP_CNT_EN
    logic                clr_cnt;
    logic [CNT_W-1:0]    clip_cnt;
`endif

    int n_vec;
    int n_err;

    pe_relu_unit #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .in_valid  (in_valid),
        .dout      (dout),
        .dout_q    (dout_q),
        .out_valid (out_valid)
`ifdef PE_RELU_CLIP_CNT_EN
        ,
        .clr_cnt   (clr_cnt),
        .clip_cnt  (clip_cnt)
`endif
    );

    // Clock only toggles once clk_run is set, so the combinational vectors
    // are applied with no clock activity at all.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    // Watchdog: the run must always reach its summary line.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] exp_dout;
    } comb_vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%06h required=0x%06h", name, act, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns before anyone samples.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        comb_vec_t comb_tbl[6];

        n_vec    = 0;
        n_err    = 0;
        clk_run  = 1'b0;
        rst_n    = 1'b0;
        din      = '0;
        in_valid = 1'b0;
`ifdef PE_RELU_CLIP_CNT_EN
        clr_cnt  = 1'b0;
`endif

        comb_tbl[0] = '{din: 24'h000000, exp_dout: 24'h000000};  //  0
        comb_tbl[1] = '{din: 24'h000007, exp_dout: 24'h000007};  //  7
        comb_tbl[2] = '{din: 24'hFFFFFF, exp_dout: 24'h000000};  // -1
        comb_tbl[3] = '{din: 24'hFE1DC0, exp_dout: 24'h000000};  // -123456
        comb_tbl[4] = '{din: 24'h7FFFFF, exp_dout: 24'h7FFFFF};  // most positive
        comb_tbl[5] = '{din: 24'h800000, exp_dout: 24'h000000};  // most negative

        // ---- reset state (asserted at time 0, no clock) ----
        #1;
        check("reset dout_q", dout_q, '0);
        check("reset out_valid", {{(W-1){1'b0}}, out_valid}, '0);
`ifdef PE_RELU_CLIP_CNT_EN
        check("reset clip_cnt", {{(W-CNT_W){1'b0}}, clip_cnt}, '0);
`endif

        // ---- combinational table, clock stopped, reset still asserted ----
        for (int i = 0; i < 6; i++) begin
            din = comb_tbl[i].din;
            #1;
            check($sformatf("comb dout[%0d]", i), dout, comb_tbl[i].exp_dout);
        end

        // ---- registered path: 5, -3, 9 back to back ----
        din     = '0;
        #2;
        rst_n   = 1'b1;
        clk_run = 1'b1;
        step();
        check("idle out_valid", {{(W-1){1'b0}}, out_valid}, '0);

        in_valid = 1'b1;
        din      = 24'sd5;
        step();
        check("seq dout_q 5", dout_q, 24'd5);
        check("seq out_valid 1", {{(W-1){1'b0}}, out_valid}, 24'd1);
        din = -24'sd3;
        step();
        check("seq dout_q -3", dout_q, 24'd0);
        check("seq out_valid 2", {{(W-1){1'b0}}, out_valid}, 24'd1);
        din = 24'sd9;
        step();
        check("seq dout_q 9", dout_q, 24'd9);
        check("seq out_valid 3", {{(W-1){1'b0}}, out_valid}, 24'd1);
        in_valid = 1'b0;
        din      = -24'sd7;
        step();
        check("hold dout_q a", dout_q, 24'd9);
        check("seq out_valid drop", {{(W-1){1'b0}}, out_valid}, '0);
        din = 24'sd100;
        step();
        check("hold dout_q b", dout_q, 24'd9);
        check("hold out_valid", {{(W-1){1'b0}}, out_valid}, '0);

        // ---- asynchronous reset while out_valid=1, between edges ----
        in_valid = 1'b1;
        din      = 24'sd11;
        step();
        check("pre-reset dout_q", dout_q, 24'd11);
        check("pre-reset out_valid", {{(W-1){1'b0}}, out_valid}, 24'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async dout_q", dout_q, '0);
        check("async out_valid", {{(W-1){1'b0}}, out_valid}, '0);
        check("async dout tracks", dout, 24'd11);
        din = -24'sd4;
        #1;
        check("reset dout neg", dout, '0);
        step();
        check("in reset out_valid", {{(W-1){1'b0}}, out_valid}, '0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        check("post-reset out_valid", {{(W-1){1'b0}}, out_valid}, '0);
        check("post-reset dout_q", dout_q, '0);
        in_valid = 1'b1;
        din      = 24'sd21;
        step();
        check("restart dout_q", dout_q, 24'd21);
        check("restart out_valid", {{(W-1){1'b0}}, out_valid}, 24'd1);
        in_valid = 1'b0;
        step();

`ifdef PE_RELU_CLIP_CNT_EN
        // ---- clip counter, CNT_W=2 saturates at 3 ----
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("cnt cleared", {{(W-CNT_W){1'b0}}, clip_cnt}, '0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [CNT_W-1:0] exp_cnt;
            exp_cnt = (i < 3) ? CNT_W'(i + 1) : CNT_W'(3);
            din = -24'sd1 - 24'(i);
            step();
            check($sformatf("cnt neg %0d", i), {{(W-CNT_W){1'b0}}, clip_cnt},
                  {{(W-CNT_W){1'b0}}, exp_cnt});
        end
        clr_cnt = 1'b1;
        din     = -24'sd8;
        step();
        clr_cnt = 1'b0;
        check("cnt clr priority", {{(W-CNT_W){1'b0}}, clip_cnt}, '0);
        din = 24'sd0;
        step();
        check("cnt zero no inc", {{(W-CNT_W){1'b0}}, clip_cnt}, '0);
        din = 24'sd6;
        step();
        check("cnt pos no inc", {{(W-CNT_W){1'b0}}, clip_cnt}, '0);
        in_valid = 1'b0;
        din      = -24'sd2;
        step();
        check("cnt invalid no inc", {{(W-CNT_W){1'b0}}, clip_cnt}, '0);
        in_valid = 1'b1;
        din      = 24'h800000;
        step();
        check("cnt min neg inc", {{(W-CNT_W){1'b0}}, clip_cnt}, 24'd1);
        in_valid = 1'b0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
